// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM bundle for the execute stage.
// The master side is whoever drives the ID/EX register and consumes the
// EX/MEM register (ID stage, MEM stage and fetch redirect logic).
// The slave side is ex_stage itself.
//   ID/EX side : in_valid/in_ready handshake, control bits, operands, rd, PC_new
//   EX/MEM side: out_valid/out_ready handshake, alu_result, store_data, rd_out,
//                registered control bits
//   Fetch side : redirect pulse, redirect_pc, squashing status
interface ex_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic        mem_read_n;
  logic        mem_write_n;
  logic        mem_to_reg_n;
  logic        reg_write_n;
  logic        jumpl_n;
  logic        branch_n;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic [3:0]  alu_select;
  logic [2:0]  func3;
  logic [4:0]  rd;
  logic [31:0] PC_new;

  logic        out_ready;
  logic        out_valid;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  rd_out;
  logic        mem_read_out;
  logic        mem_write_out;
  logic        mem_to_reg_out;
  logic        reg_write_out;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic        squashing;

  modport master (
    output in_valid, mem_read_n, mem_write_n, mem_to_reg_n, reg_write_n,
           jumpl_n, branch_n, A, B, rs2_data, imm, alu_select, func3, rd,
           PC_new, out_ready,
    input  in_ready, out_valid, alu_result, store_data, rd_out, mem_read_out,
           mem_write_out, mem_to_reg_out, reg_write_out, redirect,
           redirect_pc, squashing
  );

  modport slave (
    input  in_valid, mem_read_n, mem_write_n, mem_to_reg_n, reg_write_n,
           jumpl_n, branch_n, A, B, rs2_data, imm, alu_select, func3, rd,
           PC_new, out_ready,
    output in_ready, out_valid, alu_result, store_data, rd_out, mem_read_out,
           mem_write_out, mem_to_reg_out, reg_write_out, redirect,
           redirect_pc, squashing
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch/jump resolution and store-data forwarding,
// registered into the EX/MEM boundary behind a valid/ready handshake.
// A taken branch or jump emits a one-cycle redirect to fetch, then the next
// SQUASH_CNT accepted (wrong-path) instructions are dropped.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low reset
//   bus   - ex_stage_if.slave (ID/EX inputs, EX/MEM outputs, redirect)
module ex_stage #(
  parameter int SQUASH_CNT = 2
) (
  input logic       clk,
  input logic       reset,
  ex_stage_if.slave bus
);
  localparam int DATA_W = 32;
  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] SQUASH = 1'b1;

  function automatic logic [DATA_W-1:0] alu_calc(
    input logic [3:0]        op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;
    sa = a;
    sb = b;
    case (op)
      4'b0000: alu_calc = a & b;
      4'b0001: alu_calc = a | b;
      4'b0010: alu_calc = a + b;
      4'b0011: alu_calc = a ^ b;
      4'b0110: alu_calc = a - b;
      4'b0100: alu_calc = a << b[4:0];
      4'b0101: alu_calc = a >> b[4:0];
      4'b1000: alu_calc = sa >>> b[4:0];
      4'b0111: alu_calc = {{(DATA_W-1){1'b0}}, sa < sb};
      4'b1001: alu_calc = {{(DATA_W-1){1'b0}}, a < b};
      default: alu_calc = '0;
    endcase
  endfunction

  function automatic logic br_cond(
    input logic [2:0]        f3,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;
    sa = a;
    sb = b;
    case (f3)
      3'b000:  br_cond = (a == b);
      3'b001:  br_cond = (a != b);
      3'b100:  br_cond = (sa < sb);
      3'b101:  br_cond = (sa >= sb);
      3'b110:  br_cond = (a < b);
      3'b111:  br_cond = (a >= b);
      default: br_cond = 1'b0;
    endcase
  endfunction

  logic [0:0]        state;
  logic [2:0]        squash_cnt;
  logic              accept;
  logic              load;
  logic              taken;
  logic [DATA_W-1:0] target;
  logic [DATA_W-1:0] result;

  logic              vld_p1;
  logic [DATA_W-1:0] alu_result_p1;
  logic [DATA_W-1:0] store_data_p1;
  logic [4:0]        rd_p1;
  logic              mem_read_p1;
  logic              mem_write_p1;
  logic              mem_to_reg_p1;
  logic              reg_write_p1;
  logic              redirect_p1;
  logic [DATA_W-1:0] redirect_pc_p1;

  // EX stage: combinational execute of the ID/EX contents
  assign bus.in_ready = !vld_p1 | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;
  // Only RUN executes; accepts during SQUASH are wrong-path and get dropped.
  assign load         = accept & (state == RUN);
  assign taken        = bus.jumpl_n | (bus.branch_n & br_cond(bus.func3, bus.A, bus.rs2_data));
  assign target       = bus.PC_new + bus.imm;
  assign result       = bus.jumpl_n ? bus.PC_new + 32'd4 : alu_calc(bus.alu_select, bus.A, bus.B);

  // EX/MEM boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1        <= 1'b0;
      mem_read_p1   <= 1'b0;
      mem_write_p1  <= 1'b0;
      mem_to_reg_p1 <= 1'b0;
      reg_write_p1  <= 1'b0;
      alu_result_p1 <= '0;
      store_data_p1 <= '0;
      rd_p1         <= '0;
    end else if (load) begin
      vld_p1        <= 1'b1;
      mem_read_p1   <= bus.mem_read_n;
      mem_write_p1  <= bus.mem_write_n;
      mem_to_reg_p1 <= bus.mem_to_reg_n;
      reg_write_p1  <= bus.reg_write_n;
      alu_result_p1 <= result;
      store_data_p1 <= bus.rs2_data;
      rd_p1         <= bus.rd;
    end else if (vld_p1 & bus.out_ready) begin
      // Drained with nothing new: clear controls so MEM sees no side effects.
      vld_p1        <= 1'b0;
      mem_read_p1   <= 1'b0;
      mem_write_p1  <= 1'b0;
      mem_to_reg_p1 <= 1'b0;
      reg_write_p1  <= 1'b0;
    end
  end

  // Redirect is independent of out_ready so it stays a single-cycle pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      redirect_p1    <= 1'b0;
      redirect_pc_p1 <= '0;
    end else begin
      redirect_p1 <= load & taken;
      if (load & taken) redirect_pc_p1 <= target;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      squash_cnt <= '0;
    end else if (load & taken) begin
      state      <= SQUASH;
      squash_cnt <= 3'(SQUASH_CNT);
    end else if ((state == SQUASH) && accept) begin
      squash_cnt <= squash_cnt - 3'd1;
      if (squash_cnt == 3'd1) state <= RUN;
    end
  end

  assign bus.out_valid      = vld_p1;
  assign bus.alu_result     = alu_result_p1;
  assign bus.store_data     = store_data_p1;
  assign bus.rd_out         = rd_p1;
  assign bus.mem_read_out   = mem_read_p1;
  assign bus.mem_write_out  = mem_write_p1;
  assign bus.mem_to_reg_out = mem_to_reg_p1;
  assign bus.reg_write_out  = reg_write_p1;
  assign bus.redirect       = redirect_p1;
  assign bus.redirect_pc    = redirect_pc_p1;
  assign bus.squashing      = (state == SQUASH);
endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: directed scenarios followed by randomized traffic,
// all checked against a transaction-level reference model.
module tb_ex_stage;
  localparam int SQ = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ex_stage_if ifc();
  ex_stage #(.SQUASH_CNT(SQ)) dut (.clk(clk), .reset(reset), .bus(ifc));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: expected EX/MEM contents plus remaining wrong-path drops
  bit          m_valid, m_redir, m_mr, m_mw, m_mtr, m_rw;
  logic [31:0] m_alu, m_store, m_rpc;
  logic [4:0]  m_rd;
  int          m_drops;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    longint unsigned ua, ub;
    sh = int'(b % 32);
    ua = longint'(a);
    ub = longint'(b);
    case (op)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return 32'((ua + ub) % 64'h1_0000_0000);
      4'd3: return a ^ b;
      4'd6: return 32'((ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000);
      4'd4: return 32'((ua * (64'd1 << sh)) % 64'h1_0000_0000);
      4'd5: return 32'(ua / (64'd1 << sh));
      4'd8: return (a >> sh) | ((a[31] && sh != 0) ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      4'd7: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd9: return (ua < ub) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit ref_branch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return int'(a) < int'(b);
      3'd5: return int'(a) >= int'(b);
      3'd6: return longint'(a) < longint'(b);
      3'd7: return longint'(a) >= longint'(b);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_redir = 0; m_mr = 0; m_mw = 0; m_mtr = 0; m_rw = 0;
    m_alu = 0; m_store = 0; m_rpc = 0; m_rd = 0; m_drops = 0;
  endtask

  task automatic idle();
    ifc.in_valid = 0; ifc.mem_read_n = 0; ifc.mem_write_n = 0; ifc.mem_to_reg_n = 0;
    ifc.reg_write_n = 0; ifc.jumpl_n = 0; ifc.branch_n = 0; ifc.A = 0; ifc.B = 0;
    ifc.rs2_data = 0; ifc.imm = 0; ifc.alu_select = 0; ifc.func3 = 0; ifc.rd = 0;
    ifc.PC_new = 0; ifc.out_ready = 1;
  endtask

  task automatic check_outputs();
    check_val("out_valid", 32'(ifc.out_valid), 32'(m_valid));
    check_val("mem_read_out", 32'(ifc.mem_read_out), 32'(m_mr));
    check_val("mem_write_out", 32'(ifc.mem_write_out), 32'(m_mw));
    check_val("mem_to_reg_out", 32'(ifc.mem_to_reg_out), 32'(m_mtr));
    check_val("reg_write_out", 32'(ifc.reg_write_out), 32'(m_rw));
    check_val("redirect", 32'(ifc.redirect), 32'(m_redir));
    check_val("squashing", 32'(ifc.squashing), 32'(m_drops > 0));
    if (m_valid) begin
      check_val("alu_result", ifc.alu_result, m_alu);
      check_val("store_data", ifc.store_data, m_store);
      check_val("rd_out", 32'(ifc.rd_out), 32'(m_rd));
    end
    if (m_redir) check_val("redirect_pc", ifc.redirect_pc, m_rpc);
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_valid"}, 32'(ifc.out_valid), 0);
    check_val({tag, "_alu"}, ifc.alu_result, 0);
    check_val({tag, "_store"}, ifc.store_data, 0);
    check_val({tag, "_rd"}, 32'(ifc.rd_out), 0);
    check_val({tag, "_ctl"}, {28'd0, ifc.mem_read_out, ifc.mem_write_out,
                              ifc.mem_to_reg_out, ifc.reg_write_out}, 0);
    check_val({tag, "_redir"}, 32'(ifc.redirect), 0);
    check_val({tag, "_rpc"}, ifc.redirect_pc, 0);
    check_val({tag, "_squash"}, 32'(ifc.squashing), 0);
  endtask

  // Inputs are already driven by the caller; advance one clock and check.
  task automatic step();
    bit acc;
    #1;
    check_val("in_ready", 32'(ifc.in_ready), 32'(!m_valid || ifc.out_ready));
    acc = ifc.in_valid && (!m_valid || ifc.out_ready);
    m_redir = 0;
    if (acc && m_drops == 0) begin
      m_valid = 1;
      m_alu   = ifc.jumpl_n ? ifc.PC_new + 32'd4 : ref_alu(ifc.alu_select, ifc.A, ifc.B);
      m_store = ifc.rs2_data;
      m_rd    = ifc.rd;
      m_mr = ifc.mem_read_n; m_mw = ifc.mem_write_n;
      m_mtr = ifc.mem_to_reg_n; m_rw = ifc.reg_write_n;
      if (ifc.jumpl_n || (ifc.branch_n && ref_branch(ifc.func3, ifc.A, ifc.rs2_data))) begin
        m_redir = 1;
        m_rpc   = ifc.PC_new + ifc.imm;
        m_drops = SQ;
      end
    end else begin
      if (acc) m_drops--;
      if (m_valid && ifc.out_ready) begin
        m_valid = 0; m_mr = 0; m_mw = 0; m_mtr = 0; m_rw = 0;
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic drive_add(input logic [31:0] a, input logic [31:0] b);
    idle();
    ifc.in_valid = 1; ifc.A = a; ifc.B = b; ifc.alu_select = 4'b0010;
    ifc.reg_write_n = 1; ifc.rd = 5'd7;
  endtask

  task automatic drive_beq();
    idle();
    ifc.in_valid = 1; ifc.branch_n = 1; ifc.A = 9; ifc.rs2_data = 9;
    ifc.func3 = 3'b000; ifc.PC_new = 32'h40; ifc.imm = 32'h10;
  endtask

  task automatic rand_inputs();
    int kind;
    kind = int'($urandom_range(0, 9));
    ifc.in_valid     = ($urandom_range(0, 3) != 0);
    ifc.out_ready    = ($urandom_range(0, 3) != 0);
    ifc.A            = $urandom;
    ifc.B            = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
    ifc.rs2_data     = ($urandom_range(0, 1) != 0) ? ifc.A : $urandom;
    ifc.imm          = $urandom;
    ifc.PC_new       = $urandom;
    ifc.alu_select   = 4'($urandom_range(0, 15));
    ifc.func3        = 3'($urandom_range(0, 7));
    ifc.rd           = 5'($urandom_range(0, 31));
    ifc.mem_read_n   = 1'($urandom_range(0, 1));
    ifc.mem_write_n  = 1'($urandom_range(0, 1));
    ifc.mem_to_reg_n = 1'($urandom_range(0, 1));
    ifc.reg_write_n  = 1'($urandom_range(0, 1));
    ifc.branch_n     = (kind >= 6 && kind <= 8);
    ifc.jumpl_n      = (kind == 9);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    // ADD
    drive_add(5, 7);
    ifc.rd = 5'd3;
    step();
    check_val("add_valid", 32'(ifc.out_valid), 1);
    check_val("add_result", ifc.alu_result, 12);
    check_val("add_rd", 32'(ifc.rd_out), 3);
    check_val("add_rw", 32'(ifc.reg_write_out), 1);

    // Store replaces the draining ADD, then sits under backpressure
    idle();
    ifc.in_valid = 1; ifc.mem_write_n = 1; ifc.A = 32'h100; ifc.B = 4;
    ifc.alu_select = 4'b0010; ifc.rs2_data = 32'hDEAD;
    step();
    drive_add(1, 1);
    ifc.out_ready = 0;
    repeat (3) begin
      step();
      check_val("st_alu", ifc.alu_result, 32'h104);
      check_val("st_data", ifc.store_data, 32'hDEAD);
      check_val("st_in_ready", 32'(ifc.in_ready), 0);
    end
    idle();
    step();
    check_val("st_drain_valid", 32'(ifc.out_valid), 0);
    check_val("st_drain_mw", 32'(ifc.mem_write_out), 0);

    // Taken BEQ: redirect, two drops, third executes
    drive_beq();
    step();
    check_val("beq_redir", 32'(ifc.redirect), 1);
    check_val("beq_rpc", ifc.redirect_pc, 32'h50);
    check_val("beq_squash", 32'(ifc.squashing), 1);
    drive_add(2, 3);
    step();
    check_val("drop1_valid", 32'(ifc.out_valid), 0);
    check_val("drop1_redir", 32'(ifc.redirect), 0);
    check_val("drop1_squash", 32'(ifc.squashing), 1);
    step();
    check_val("drop2_valid", 32'(ifc.out_valid), 0);
    check_val("drop2_squash", 32'(ifc.squashing), 0);
    step();
    check_val("post_valid", 32'(ifc.out_valid), 1);
    check_val("post_alu", ifc.alu_result, 5);

    // Not-taken BNE
    drive_beq();
    ifc.func3 = 3'b001;
    step();
    check_val("bne_redir", 32'(ifc.redirect), 0);
    check_val("bne_squash", 32'(ifc.squashing), 0);

    // JAL, then the redirect pulse under MEM backpressure
    idle();
    ifc.in_valid = 1; ifc.jumpl_n = 1; ifc.reg_write_n = 1;
    ifc.PC_new = 32'h20; ifc.imm = 8; ifc.rd = 1;
    step();
    check_val("jal_alu", ifc.alu_result, 32'h24);
    check_val("jal_rpc", ifc.redirect_pc, 32'h28);
    check_val("jal_rw", 32'(ifc.reg_write_out), 1);
    check_val("jal_redir", 32'(ifc.redirect), 1);
    idle();
    ifc.out_ready = 0;
    step();
    check_val("jal_bp_redir", 32'(ifc.redirect), 0);
    check_val("jal_bp_valid", 32'(ifc.out_valid), 1);
    drive_add(4, 4);
    repeat (2) step();
    check_val("jal_done_squash", 32'(ifc.squashing), 0);

    // Reset in the middle of a squash
    drive_beq();
    step();
    drive_add(6, 6);
    step();
    check_val("mid_squash", 32'(ifc.squashing), 1);
    #2 reset = 1'b0;
    #1;
    check_zero("midrst");
    model_reset();
    idle();
    @(negedge clk);
    reset = 1'b1;
    drive_add(3, 4);
    step();
    check_val("rst_exec_valid", 32'(ifc.out_valid), 1);
    check_val("rst_exec_alu", ifc.alu_result, 7);
    check_val("rst_exec_squash", 32'(ifc.squashing), 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
